// File: rtl/data_mem_unit.sv
// Word-organised data memory with RISC-V byte/halfword/word loads and stores.
// Word-crossing misaligned accesses either trap or run as two word beats.
module data_mem_unit #(
    parameter int DEPTH_WORDS      = 1024,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [2:0]  rsp_err
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] BYTE_CAP = 33'(DEPTH_WORDS) << 2;

    // Handshake: a request is accepted on a rising edge where req_valid and
    // req_ready are both high; rsp_valid is a single-cycle pulse, never stalled.
    typedef enum logic {IDLE, SPLIT} state_t;
    state_t state;

    logic [31:0] mem [DEPTH_WORDS];

    logic             funct3_ok;
    logic [2:0]       size;
    logic [32:0]      last_byte;
    logic             range_bad;
    logic             misaligned;
    logic             crossing;
    logic [2:0]       err;
    logic             accept;
    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic [7:0]       mask8;
    logic [63:0]      wdata64;
    logic [31:0]      rd_word;
    logic [31:0]      single_raw;

    logic [IDX_W-1:0] split_idx;
    logic [1:0]       split_off;
    logic [2:0]       split_funct3;
    logic             split_we;
    logic [31:0]      split_lo;
    logic [3:0]       split_mask;
    logic [31:0]      split_wdata;
    logic [31:0]      split_raw;

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [3:0]       wr_mask;
    logic [31:0]      wr_data;

    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] raw);
        logic [31:0] res;
        case (f3)
            3'b000:  res = {{24{raw[7]}}, raw[7:0]};
            3'b001:  res = {{16{raw[15]}}, raw[15:0]};
            3'b100:  res = {24'b0, raw[7:0]};
            3'b101:  res = {16'b0, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // Illegal funct3 is treated as a one-byte access so it reports only bit2
    // unless the addressed byte itself is out of range.
    always_comb begin
        funct3_ok = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
            3'b100, 3'b101:         funct3_ok = !req_we;
            default:                funct3_ok = 1'b0;
        endcase
        size = 3'd1;
        if (funct3_ok) begin
            case (req_funct3[1:0])
                2'b01:   size = 3'd2;
                2'b10:   size = 3'd4;
                default: size = 3'd1;
            endcase
        end
    end

    assign last_byte  = {1'b0, req_addr} + {30'b0, size} - 33'd1;
    assign range_bad  = last_byte >= BYTE_CAP;
    assign misaligned = (size == 3'd2 && req_addr[0]) || (size == 3'd4 && req_addr[1:0] != 2'b00);
    assign crossing   = ({2'b00, req_addr[1:0]} + {1'b0, size}) > 4'd4;
    assign err        = {!funct3_ok, range_bad, misaligned && !SPLIT_MISALIGNED};

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    assign idx        = req_addr[IDX_W+1:2];
    assign off        = req_addr[1:0];
    assign mask8      = (size == 3'd4 ? 8'h0F : size == 3'd2 ? 8'h03 : 8'h01) << off;
    assign wdata64    = {32'b0, req_wdata} << {off, 3'b000};
    assign rd_word    = mem[idx];
    assign single_raw = rd_word >> {off, 3'b000};
    assign split_raw  = 32'({mem[split_idx], split_lo} >> {split_off, 3'b000});

    // Byte lanes above bit 31 of the shifted data/mask belong to word N+1.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = idx;
        wr_mask = mask8[3:0];
        wr_data = wdata64[31:0];
        if (state == SPLIT) begin
            wr_en   = split_we && !reset;
            wr_idx  = split_idx;
            wr_mask = split_mask;
            wr_data = split_wdata;
        end else begin
            wr_en = accept && req_we && (err == 3'b000);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'b0;
            rsp_err      <= 3'b0;
            split_idx    <= '0;
            split_off    <= 2'b0;
            split_funct3 <= 3'b0;
            split_we     <= 1'b0;
            split_lo     <= 32'b0;
            split_mask   <= 4'b0;
            split_wdata  <= 32'b0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid <= 1'b0;
                    if (accept) begin
                        if (err != 3'b000) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= 32'b0;
                            rsp_err   <= err;
                        end else if (crossing) begin
                            state        <= SPLIT;
                            split_idx    <= idx + IDX_W'(1);
                            split_off    <= off;
                            split_funct3 <= req_funct3;
                            split_we     <= req_we;
                            split_lo     <= rd_word;
                            split_mask   <= mask8[7:4];
                            split_wdata  <= wdata64[63:32];
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= req_we ? 32'b0 : extend_load(req_funct3, single_raw);
                            rsp_err   <= 3'b000;
                        end
                    end
                end
                SPLIT: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= split_we ? 32'b0 : extend_load(split_funct3, split_raw);
                    rsp_err   <= 3'b000;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: one split-mode and one trap-mode instance, directed
// steps plus random traffic scored against a byte-array model.
module tb_data_mem_unit;

    localparam int DEPTH = 64;
    localparam int BYTES = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        s_req_valid, s_req_ready, s_req_we, s_rsp_valid;
    logic [2:0]  s_req_funct3, s_rsp_err;
    logic [31:0] s_req_addr, s_req_wdata, s_rsp_rdata;
    logic        t_req_valid, t_req_ready, t_req_we, t_rsp_valid;
    logic [2:0]  t_req_funct3, t_rsp_err;
    logic [31:0] t_req_addr, t_req_wdata, t_rsp_rdata;

    data_mem_unit #(.DEPTH_WORDS(DEPTH), .SPLIT_MISALIGNED(1'b1)) dut_s (
        .clk(clk), .reset(reset),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_we(s_req_we),
        .req_funct3(s_req_funct3), .req_addr(s_req_addr), .req_wdata(s_req_wdata),
        .rsp_valid(s_rsp_valid), .rsp_rdata(s_rsp_rdata), .rsp_err(s_rsp_err)
    );

    data_mem_unit #(.DEPTH_WORDS(DEPTH), .SPLIT_MISALIGNED(1'b0)) dut_t (
        .clk(clk), .reset(reset),
        .req_valid(t_req_valid), .req_ready(t_req_ready), .req_we(t_req_we),
        .req_funct3(t_req_funct3), .req_addr(t_req_addr), .req_wdata(t_req_wdata),
        .rsp_valid(t_rsp_valid), .rsp_rdata(t_rsp_rdata), .rsp_err(t_rsp_err)
    );

    int          total_cnt = 0;
    int          pass_cnt  = 0;
    int          cyc = 0;
    int          ready_low_cyc = -1;
    bit          abort_split = 1'b0;
    logic [7:0]  model_s [BYTES];
    logic [66:0] exp_q [$];   // {due cycle, rdata, err}

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Reference: byte-granular memory, size/legality/range from the access rules.
    task automatic model_accept(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd);
        bit          legal;
        int          size, off, lat, a;
        longint      last, val;
        logic [2:0]  e;
        logic [31:0] rd;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size  = !legal ? 1 : (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        last  = longint'(addr) + longint'(size) - 1;
        e     = {!legal, last >= longint'(BYTES), 1'b0};
        off   = int'(addr[1:0]);
        lat   = (e == 3'b000 && off + size > 4) ? 2 : 1;
        rd    = 32'b0;
        if (e == 3'b000) begin
            a = int'(addr[7:0]);
            if (we) begin
                for (int i = 0; i < size; i++) begin
                    if (!abort_split || (a + i) / 4 == a / 4) model_s[a + i] = wd[8*i +: 8];
                end
            end else begin
                val = 0;
                for (int i = 0; i < size; i++) val += longint'(model_s[a + i]) << (8 * i);
                if (!f3[2] && size < 4 && val[8*size-1]) val -= (longint'(1) << (8 * size));
                rd = val[31:0];
            end
        end
        if (abort_split && lat == 2) return;
        exp_q.push_back({32'(cyc + lat), rd, e});
        if (lat == 2) ready_low_cyc = cyc + 1;
    endtask

    // One clock of the split-mode instance: score outputs, then drive the next request.
    task automatic step(input bit v, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
        bit          due;
        logic [66:0] e;
        @(negedge clk);
        cyc++;
        check("s_req_ready", 32'(s_req_ready), 32'(cyc != ready_low_cyc));
        due = (exp_q.size() > 0) && (exp_q[0][66:35] == 32'(cyc));
        check("s_rsp_valid", 32'(s_rsp_valid), 32'(due));
        if (due) begin
            e = exp_q.pop_front();
            check("s_rsp_rdata", s_rsp_rdata, e[34:3]);
            check("s_rsp_err", 32'(s_rsp_err), 32'(e[2:0]));
        end
        s_req_valid  = v;
        s_req_we     = we;
        s_req_funct3 = f3;
        s_req_addr   = addr;
        s_req_wdata  = wd;
        if (v && cyc != ready_low_cyc) model_accept(we, f3, addr, wd);
    endtask

    task automatic t_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic [2:0] exp_err,
                         input string tag);
        @(negedge clk);
        check({tag, " ready"}, 32'(t_req_ready), 32'd1);
        t_req_valid  = 1'b1;
        t_req_we     = we;
        t_req_funct3 = f3;
        t_req_addr   = addr;
        t_req_wdata  = wd;
        @(negedge clk);
        t_req_valid = 1'b0;
        check({tag, " valid"}, 32'(t_rsp_valid), 32'd1);
        check({tag, " rdata"}, t_rsp_rdata, exp_rd);
        check({tag, " err"}, 32'(t_rsp_err), 32'(exp_err));
    endtask

    initial begin
        int          legal_f3 [5] = '{0, 1, 2, 4, 5};
        int          r;
        bit          v, we;
        logic [2:0]  f3;
        logic [31:0] addr;

        reset = 1'b1;
        s_req_valid = 1'b0; s_req_we = 1'b0; s_req_funct3 = 3'b0; s_req_addr = 32'b0; s_req_wdata = 32'b0;
        t_req_valid = 1'b0; t_req_we = 1'b0; t_req_funct3 = 3'b0; t_req_addr = 32'b0; t_req_wdata = 32'b0;
        repeat (3) @(negedge clk);
        check("reset s_req_ready", 32'(s_req_ready), 32'd0);
        check("reset t_req_ready", 32'(t_req_ready), 32'd0);
        check("reset s_rsp_valid", 32'(s_rsp_valid), 32'd0);
        check("reset s_rsp_rdata", s_rsp_rdata, 32'd0);
        check("reset s_rsp_err", 32'(s_rsp_err), 32'd0);
        check("reset t_rsp_valid", 32'(t_rsp_valid), 32'd0);
        reset = 1'b0;

        // Trap-mode instance, directed.
        t_req(1'b1, 3'd2, 32'h00, 32'h11223344, 32'h0, 3'b000, "t_sw0");
        t_req(1'b0, 3'd1, 32'h01, 32'h0, 32'h0, 3'b001, "t_lh_odd");
        t_req(1'b1, 3'd2, 32'h02, 32'hFFFFFFFF, 32'h0, 3'b001, "t_sw_mis");
        t_req(1'b1, 3'd1, 32'h03, 32'h0000FFFF, 32'h0, 3'b001, "t_sh_mis");
        t_req(1'b0, 3'd2, 32'h00, 32'h0, 32'h11223344, 3'b000, "t_lw0");
        t_req(1'b0, 3'd1, 32'h02, 32'h0, 32'h00001122, 3'b000, "t_lh2");
        t_req(1'b0, 3'd5, 32'h03, 32'h0, 32'h0, 3'b001, "t_lhu3");
        t_req(1'b0, 3'd2, 32'(BYTES - 2), 32'h0, 32'h0, 3'b011, "t_lw_top");
        t_req(1'b0, 3'd3, 32'h00, 32'h0, 32'h0, 3'b100, "t_ld_ill");
        t_req(1'b0, 3'd4, 32'h03, 32'h0, 32'h00000011, 3'b000, "t_lbu3");

        // Split-mode instance: preload every word so the model is fully known.
        for (int w = 0; w < DEPTH; w++) step(1'b1, 1'b1, 3'd2, 32'(4 * w), $urandom());
        step(1'b1, 1'b1, 3'd2, 32'h10, 32'h8899AABB);
        step(1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
        step(1'b1, 1'b0, 3'd0, 32'h13, 32'h0);
        step(1'b1, 1'b0, 3'd4, 32'h13, 32'h0);
        step(1'b1, 1'b1, 3'd1, 32'h12, 32'h00001234);
        step(1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
        step(1'b1, 1'b1, 3'd2, 32'h0E, 32'hDEADBEEF);
        step(1'b1, 1'b0, 3'd2, 32'h0C, 32'h0);
        step(1'b1, 1'b0, 3'd2, 32'h0C, 32'h0);
        step(1'b1, 1'b0, 3'd5, 32'h10, 32'h0);
        step(1'b1, 1'b0, 3'd1, 32'h01, 32'h0);
        step(1'b1, 1'b0, 3'd2, 32'h03, 32'h0);
        step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 3'd1, 32'h07, 32'h0);
        step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 3'd2, 32'(BYTES - 2), 32'h0);
        step(1'b1, 1'b0, 3'd3, 32'h20, 32'h0);
        step(1'b1, 1'b1, 3'd4, 32'h24, 32'h55667788);
        step(1'b1, 1'b0, 3'd2, 32'h20, 32'h0);
        step(1'b1, 1'b0, 3'd2, 32'h24, 32'h0);
        step(1'b1, 1'b0, 3'd2, 32'(BYTES - 4), 32'h0);
        step(1'b1, 1'b0, 3'd0, 32'(BYTES - 1), 32'h0);
        step(1'b1, 1'b0, 3'd1, 32'(BYTES - 1), 32'h0);
        step(1'b1, 1'b0, 3'd2, 32'h80000010, 32'h0);
        step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);

        // Reset lands on the second beat of a split store.
        abort_split = 1'b1;
        step(1'b1, 1'b1, 3'd2, 32'h2E, 32'hCAFEF00D);
        abort_split = 1'b0;
        @(negedge clk);
        cyc++;
        check("split s_req_ready", 32'(s_req_ready), 32'd0);
        s_req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        cyc++;
        check("abort s_rsp_valid", 32'(s_rsp_valid), 32'd0);
        check("abort s_req_ready", 32'(s_req_ready), 32'd0);
        reset = 1'b0;
        step(1'b1, 1'b0, 3'd2, 32'h2C, 32'h0);
        step(1'b1, 1'b0, 3'd2, 32'h30, 32'h0);

        // Random traffic.
        repeat (500) begin
            r  = $urandom_range(0, 99);
            v  = ($urandom_range(0, 99) < 85);
            we = 1'($urandom_range(0, 1));
            f3 = we ? 3'(legal_f3[$urandom_range(0, 2)]) : 3'(legal_f3[$urandom_range(0, 4)]);
            if (r < 75)      addr = 32'($urandom_range(0, BYTES - 1));
            else if (r < 90) addr = 32'(BYTES - 8 + $urandom_range(0, 7));
            else             addr = $urandom() | 32'h00000100;
            if ($urandom_range(0, 99) < 8) begin
                f3   = we ? 3'($urandom_range(3, 7)) : 3'(legal_f3[$urandom_range(0, 1)] + 3);
                f3   = (!we && f3 == 3'd4) ? 3'd6 : f3;
                addr = 32'(4 * $urandom_range(0, DEPTH - 2));
            end
            step(v, we, f3, addr, $urandom());
        end
        repeat (3) step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        check("s_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
